// File: rtl/tva_pkg.sv
// Shared types and constants for the ViT reconstruction head.
package tva_pkg;

  localparam int unsigned ACC_WIDTH = 32;

  typedef enum logic [2:0] {
    StIdle,
    StWaitTok,
    StSetup,
    StMac,
    StEmit,
    StDone
  } unemb_state_t;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/patch_coord_gen.sv
// Maps (patch index, pixel offset in patch) to image (y, x, c); purely combinational.
module patch_coord_gen
  import tva_pkg::*;
#(
  parameter int unsigned IMG_H = 32,
  parameter int unsigned IMG_W = 32,
  parameter int unsigned C     = 3,
  parameter int unsigned PH    = 8,
  parameter int unsigned PW    = 8
) (
  input  logic [cnt_w((IMG_H / PH) * (IMG_W / PW))-1:0] patch_idx_i,
  input  logic [cnt_w(PH * PW * C)-1:0]                 px_i,
  output logic [$clog2(IMG_H)-1:0]                      y_o,
  output logic [$clog2(IMG_W)-1:0]                      x_o,
  output logic [$clog2(C):0]                            c_o
);

  localparam int unsigned PatchesPerRow = IMG_W / PW;
  localparam int unsigned RowPx         = PW * C;
  localparam int unsigned YW            = $clog2(IMG_H);
  localparam int unsigned XW            = $clog2(IMG_W);
  localparam int unsigned CW            = $clog2(C) + 1;

  logic [31:0] pidx, pxv, pcy, pcx, ly, lx;

  always_comb begin
    pidx = 32'(patch_idx_i);
    pxv  = 32'(px_i);
    pcy  = pidx / PatchesPerRow;
    pcx  = pidx % PatchesPerRow;
    ly   = pxv / RowPx;
    lx   = (pxv % RowPx) / C;
    y_o  = YW'(pcy * PH + ly);
    x_o  = XW'(pcx * PW + lx);
    c_o  = CW'(pxv % C);
  end

endmodule

// File: rtl/patch_unembedding.sv
// Projects embedding tokens back to pixel patches and streams pixels with image coordinates.
// Optional SATURATE_EN: clamp pixels to all-ones on accumulator overflow instead of truncating.
module patch_unembedding
  import tva_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned IMG_H      = 32,
  parameter int unsigned IMG_W      = 32,
  parameter int unsigned C          = 3,
  parameter int unsigned PH         = 8,
  parameter int unsigned PW         = 8,
  parameter int unsigned E          = 64
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start_i,
  output logic                                  done_o,
  input  logic                                  tok_valid_i,
  output logic                                  tok_ready_o,
  input  logic [DATA_WIDTH*E-1:0]               tok_data_i,
  input  logic [DATA_WIDTH*E*PH*PW*C-1:0]       w_unemb_i,
  input  logic [DATA_WIDTH*PH*PW*C-1:0]         b_unemb_i,
  output logic                                  pix_valid_o,
  input  logic                                  pix_ready_i,
  output logic [DATA_WIDTH-1:0]                 pix_data_o,
  output logic [$clog2(IMG_H)-1:0]              pix_y_o,
  output logic [$clog2(IMG_W)-1:0]              pix_x_o,
  output logic [$clog2(C):0]                    pix_c_o,
  output logic                                  pix_last_o
);

  localparam int unsigned PatchSize  = PH * PW * C;
  localparam int unsigned NumPatches = (IMG_H / PH) * (IMG_W / PW);
  localparam int unsigned PIdxW      = cnt_w(NumPatches);
  localparam int unsigned PxW        = cnt_w(PatchSize);
  localparam int unsigned ECntW      = cnt_w(E);

  unemb_state_t            state_q;
  logic [PIdxW-1:0]        patch_idx_q;
  logic [PxW-1:0]          px_q;
  logic [ECntW-1:0]        e_cnt_q;
  logic [ACC_WIDTH-1:0]    acc_q;
  logic [DATA_WIDTH-1:0]   tok_q [E];
  logic                    done_q, tok_ready_q, pix_valid_q, pix_last_q;
  logic [DATA_WIDTH-1:0]   pix_data_q;
  logic [$clog2(IMG_H)-1:0] pix_y_q;
  logic [$clog2(IMG_W)-1:0] pix_x_q;
  logic [$clog2(C):0]      pix_c_q;

  logic [DATA_WIDTH-1:0]   tok_arr [E];
  logic [DATA_WIDTH-1:0]   w_arr [E][PatchSize];
  logic [DATA_WIDTH-1:0]   b_arr [PatchSize];

  for (genvar g = 0; g < E; g++) begin : g_tok
    assign tok_arr[g] = tok_data_i[g*DATA_WIDTH +: DATA_WIDTH];
    for (genvar p = 0; p < PatchSize; p++) begin : g_w
      assign w_arr[g][p] = w_unemb_i[(g*PatchSize+p)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  for (genvar p = 0; p < PatchSize; p++) begin : g_b
    assign b_arr[p] = b_unemb_i[p*DATA_WIDTH +: DATA_WIDTH];
  end

  logic [$clog2(IMG_H)-1:0] cy;
  logic [$clog2(IMG_W)-1:0] cx;
  logic [$clog2(C):0]       cc;

  patch_coord_gen #(
    .IMG_H (IMG_H),
    .IMG_W (IMG_W),
    .C     (C),
    .PH    (PH),
    .PW    (PW)
  ) u_coord (
    .patch_idx_i (patch_idx_q),
    .px_i        (px_q),
    .y_o         (cy),
    .x_o         (cx),
    .c_o         (cc)
  );

  logic [2*DATA_WIDTH-1:0] prod;
  logic [ACC_WIDTH-1:0]    acc_mac;
  logic [DATA_WIDTH-1:0]   pix_res;

  always_comb begin
    prod    = {{DATA_WIDTH{1'b0}}, tok_q[e_cnt_q]} * {{DATA_WIDTH{1'b0}}, w_arr[e_cnt_q][px_q]};
    acc_mac = acc_q + ACC_WIDTH'(prod);
`ifdef SATURATE_EN
    pix_res = (acc_q[ACC_WIDTH-1:DATA_WIDTH] != '0) ? '1 : acc_q[DATA_WIDTH-1:0];
`else
    pix_res = acc_q[DATA_WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      patch_idx_q <= '0;
      px_q        <= '0;
      e_cnt_q     <= '0;
      acc_q       <= '0;
      done_q      <= 1'b0;
      tok_ready_q <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_last_q  <= 1'b0;
      pix_data_q  <= '0;
      pix_y_q     <= '0;
      pix_x_q     <= '0;
      pix_c_q     <= '0;
      for (int i = 0; i < E; i++) tok_q[i] <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            patch_idx_q <= '0;
            px_q        <= '0;
            tok_ready_q <= 1'b1;
            state_q     <= StWaitTok;
          end
        end
        StWaitTok: begin
          if (tok_valid_i) begin
            for (int i = 0; i < E; i++) tok_q[i] <= tok_arr[i];
            tok_ready_q <= 1'b0;
            state_q     <= StSetup;
          end
        end
        StSetup: begin
          acc_q   <= ACC_WIDTH'(b_arr[px_q]);
          e_cnt_q <= '0;
          state_q <= StMac;
        end
        StMac: begin
          acc_q <= acc_mac;
          if (e_cnt_q == ECntW'(E - 1)) state_q <= StEmit;
          else e_cnt_q <= e_cnt_q + ECntW'(1);
        end
        StEmit: begin
          // First EMIT cycle registers the finished pixel; later cycles wait for the accept.
          if (!pix_valid_q) begin
            pix_valid_q <= 1'b1;
            pix_data_q  <= pix_res;
            pix_y_q     <= cy;
            pix_x_q     <= cx;
            pix_c_q     <= cc;
            pix_last_q  <= (patch_idx_q == PIdxW'(NumPatches - 1)) &&
                           (px_q == PxW'(PatchSize - 1));
          end else if (pix_ready_i) begin
            pix_valid_q <= 1'b0;
            pix_last_q  <= 1'b0;
            if (px_q != PxW'(PatchSize - 1)) begin
              px_q    <= px_q + PxW'(1);
              state_q <= StSetup;
            end else if (patch_idx_q != PIdxW'(NumPatches - 1)) begin
              patch_idx_q <= patch_idx_q + PIdxW'(1);
              px_q        <= '0;
              tok_ready_q <= 1'b1;
              state_q     <= StWaitTok;
            end else begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign done_o      = done_q;
  assign tok_ready_o = tok_ready_q;
  assign pix_valid_o = pix_valid_q;
  assign pix_last_o  = pix_last_q;
  assign pix_data_o  = pix_data_q;
  assign pix_y_o     = pix_y_q;
  assign pix_x_o     = pix_x_q;
  assign pix_c_o     = pix_c_q;

endmodule

// File: tb/tb_patch_unembedding.sv
// Directed bench for patch_unembedding on a 4x4, C=1, 2x2-patch, E=2 configuration.
module tb_patch_unembedding;

  localparam int unsigned DW = 16;
  localparam int unsigned EE = 2;
  localparam int unsigned PS = 4;
`ifdef SATURATE_EN
  localparam logic [15:0] SatExp = 16'hFFFF;
`else
  localparam logic [15:0] SatExp = 16'hFFFC;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             done;
  logic             tok_valid = 1'b0;
  logic             tok_ready;
  logic [DW*EE-1:0] tok_data = '0;
  logic [DW*EE*PS-1:0] w_unemb = '0;
  logic [DW*PS-1:0] b_unemb = '0;
  logic             pix_valid;
  logic             pix_ready = 1'b0;
  logic [DW-1:0]    pix_data;
  logic [1:0]       pix_y, pix_x;
  logic [0:0]       pix_c;
  logic             pix_last;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  patch_unembedding #(
    .DATA_WIDTH (16),
    .IMG_H      (4),
    .IMG_W      (4),
    .C          (1),
    .PH         (2),
    .PW         (2),
    .E          (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .done_o      (done),
    .tok_valid_i (tok_valid),
    .tok_ready_o (tok_ready),
    .tok_data_i  (tok_data),
    .w_unemb_i   (w_unemb),
    .b_unemb_i   (b_unemb),
    .pix_valid_o (pix_valid),
    .pix_ready_i (pix_ready),
    .pix_data_o  (pix_data),
    .pix_y_o     (pix_y),
    .pix_x_o     (pix_x),
    .pix_c_o     (pix_c),
    .pix_last_o  (pix_last)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input logic [15:0] wv, input bit bias_is_px);
    for (int e = 0; e < int'(EE); e++)
      for (int p = 0; p < int'(PS); p++) w_unemb[(e*PS+p)*DW +: DW] = wv;
    for (int p = 0; p < int'(PS); p++) b_unemb[p*DW +: DW] = bias_is_px ? 16'(p) : 16'h0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("tok_ready_after_start", tok_ready, 1);
  endtask

  task automatic send_token(input logic [15:0] t0, input logic [15:0] t1);
    int n;
    tok_data  = {t1, t0};
    tok_valid = 1'b1;
    n = 0;
    while (tok_ready !== 1'b1 && n < 50) begin tick(); n++; end
    check("tok_ready_wait", tok_ready, 1);
    tick();
    tok_valid = 1'b0;
    tok_data  = '0;
    check("tok_ready_low_after_hs", tok_ready, 0);
  endtask

  task automatic get_pixel(input int p, input int i, input logic [15:0] exp, input int stall);
    int n;
    logic [31:0] ey, ex;
    ey = 32'((p / 2) * 2 + i / 2);
    ex = 32'((p % 2) * 2 + i % 2);
    n = 0;
    while (pix_valid !== 1'b1 && n < 50) begin tick(); n++; end
    check("pix_latency", n, 4);
    check("pix_data", pix_data, exp);
    check("pix_y", pix_y, ey);
    check("pix_x", pix_x, ex);
    check("pix_c", pix_c, 0);
    check("pix_last", pix_last, (p == 3 && i == 3) ? 1 : 0);
    check("tok_ready_in_emit", tok_ready, 0);
    for (int k = 0; k < stall; k++) begin
      tick();
      check("stall_valid", pix_valid, 1);
      check("stall_data", pix_data, exp);
      check("stall_y", pix_y, ey);
      check("stall_x", pix_x, ex);
    end
    pix_ready = 1'b1;
    tick();
    pix_ready = 1'b0;
    check("pix_valid_drop", pix_valid, 0);
  endtask

  task automatic run_patch(input int p, input logic [15:0] t0, input logic [15:0] t1,
                           input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [15:0] e3, input int stall);
    send_token(t0, t1);
    get_pixel(p, 0, e0, stall);
    get_pixel(p, 1, e1, 0);
    get_pixel(p, 2, e2, 0);
    get_pixel(p, 3, e3, 0);
  endtask

  task automatic finish_frame();
    check("done_pulse", done, 1);
    tick();
    check("done_clear", done, 0);
    check("idle_tok_ready", tok_ready, 0);
    check("idle_pix_valid", pix_valid, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_done"}, done, 0);
    check({tag, "_tok_ready"}, tok_ready, 0);
    check({tag, "_pix_valid"}, pix_valid, 0);
    check({tag, "_pix_last"}, pix_last, 0);
    check({tag, "_pix_data"}, pix_data, 0);
    check({tag, "_pix_y"}, pix_y, 0);
    check({tag, "_pix_x"}, pix_x, 0);
    check({tag, "_pix_c"}, pix_c, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    tick();
    tick();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    tick();

    // Frame 1: W=1, b=0; third patch stalls its first pixel for 5 cycles.
    set_wb(16'd1, 1'b0);
    do_start();
    run_patch(0, 16'd3, 16'd5, 16'd8, 16'd8, 16'd8, 16'd8, 0);
    run_patch(1, 16'd1, 16'd1, 16'd2, 16'd2, 16'd2, 16'd2, 0);
    run_patch(2, 16'd2, 16'd7, 16'd9, 16'd9, 16'd9, 16'd9, 5);
    run_patch(3, 16'd0, 16'd4, 16'd4, 16'd4, 16'd4, 16'd4, 0);
    finish_frame();

    // Frame 2: W=1, b[px]=px; aborted by reset during MAC of patch 2.
    set_wb(16'd1, 1'b1);
    do_start();
    run_patch(0, 16'd3, 16'd5, 16'd8, 16'd9, 16'd10, 16'd11, 0);
    run_patch(1, 16'd1, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 0);
    send_token(16'd9, 16'd9);
    tick();
    rst_n = 1'b0;
    #1;
    check_outputs_zero("abort");
    tick();
    rst_n = 1'b1;
    tick();

    // Frame 3: W=2, b=0; first patch overflows 16 bits (acc = 0x3FFFC).
    set_wb(16'd2, 1'b0);
    do_start();
    run_patch(0, 16'hFFFF, 16'hFFFF, SatExp, SatExp, SatExp, SatExp, 0);
    run_patch(1, 16'd1, 16'd2, 16'd6, 16'd6, 16'd6, 16'd6, 0);
    run_patch(2, 16'h10, 16'h20, 16'h60, 16'h60, 16'h60, 16'h60, 0);
    run_patch(3, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 0);
    finish_frame();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
